// File: rtl/game_round_ctl.sv
// Round timer and score keeper for the car game: counts vsync frames into
// seconds, runs the round countdown and accumulates per-player hit counts.
module game_round_ctl #(
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter int unsigned FRAMES_PER_SEC = 60
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       players_sel,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic       TimeOut,
  output logic       NoOfPlayers,
  output logic [7:0] Player1Score,
  output logic [7:0] Player2Score,
  output logic [7:0] seconds_left,
  output logic       round_active
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUNNING   = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  localparam logic [7:0] ROUND_LOAD = 8'(ROUND_SECONDS);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);

  state_t     r_state;
  logic       r_vsync_d;
  logic       r_start_d;
  logic       r_p1_d;
  logic       r_p2_d;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_seconds_left;
  logic [7:0] r_p1_score;
  logic [7:0] r_p2_score;
  logic       r_time_out;
  logic       r_num_players;
  logic       r_round_active;

  logic w_vsync_edge;
  logic w_start_edge;
  logic w_p1_edge;
  logic w_p2_edge;
  logic w_frame_wrap;
  logic w_sec_tick;
  logic w_last_second;

  // A held level produces exactly one event: high now, low on the previous cycle.
  assign w_vsync_edge  = vsync_in & ~r_vsync_d;
  assign w_start_edge  = start    & ~r_start_d;
  assign w_p1_edge     = p1_hit   & ~r_p1_d;
  assign w_p2_edge     = p2_hit   & ~r_p2_d;

  assign w_frame_wrap  = (r_frame_cnt == FRAME_LAST);
  assign w_sec_tick    = (r_state == S_RUNNING) && w_vsync_edge && w_frame_wrap;
  assign w_last_second = (r_seconds_left == 8'd1);

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // NOTE: every register below uses non-blocking assignment so all flops sample
  // the same pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_start_d <= 1'b0;
      r_p1_d    <= 1'b0;
      r_p2_d    <= 1'b0;
    end else begin
      r_vsync_d <= vsync_in;
      r_start_d <= start;
      r_p1_d    <= p1_hit;
      r_p2_d    <= p2_hit;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_frame_cnt    <= 8'd0;
      r_seconds_left <= ROUND_LOAD;
      r_p1_score     <= 8'd0;
      r_p2_score     <= 8'd0;
      r_time_out     <= 1'b0;
      r_num_players  <= 1'b0;
      r_round_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_GAME_OVER: begin
          // Hits and vsync are ignored here; only a start edge reloads the round.
          if (w_start_edge) begin
            r_state        <= S_RUNNING;
            r_frame_cnt    <= 8'd0;
            r_seconds_left <= ROUND_LOAD;
            r_p1_score     <= 8'd0;
            r_p2_score     <= 8'd0;
            r_time_out     <= 1'b0;
            r_num_players  <= players_sel;
            r_round_active <= 1'b1;
          end
        end

        S_RUNNING: begin
          if (w_vsync_edge) begin
            r_frame_cnt <= w_frame_wrap ? 8'd0 : r_frame_cnt + 8'd1;
          end

          // Hits on the final tick still count: scoring is independent of the exit.
          if (w_p1_edge) begin
            r_p1_score <= sat_inc(r_p1_score);
          end
          if (w_p2_edge && r_num_players) begin
            r_p2_score <= sat_inc(r_p2_score);
          end

          if (w_sec_tick) begin
            if (w_last_second) begin
              r_state        <= S_GAME_OVER;
              r_seconds_left <= 8'd0;
              r_time_out     <= 1'b1;
              r_round_active <= 1'b0;
            end else begin
              r_seconds_left <= r_seconds_left - 8'd1;
            end
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_round_active <= 1'b0;
        end
      endcase
    end
  end

  assign TimeOut      = r_time_out;
  assign NoOfPlayers  = r_num_players;
  assign Player1Score = r_p1_score;
  assign Player2Score = r_p2_score;
  assign seconds_left = r_seconds_left;
  assign round_active = r_round_active;

endmodule
